// File: rtl/estagio_operandos.sv
// Operand-issue stage feeding the nRISC ALU: register bank, busy scoreboard,
// write-back bypass and a one-entry valid/ready operand register.
module estagio_operandos #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Fonte1,
  output logic [WIDTH-1:0] Fonte2,
  output logic [1:0]       ULAOp,
  output logic [AW-1:0]    out_rd,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_rd,
  input  logic [WIDTH-1:0] wb_data
);

  localparam int unsigned NREG = 1 << AW;

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  ebusy;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             wb_act;
  logic             hazard;
  logic             space;
  logic             issue;

  assign wb_act = wb_en && (wb_rd != '0);

  // Operand reads: r0 reads zero, a same-cycle write-back is forwarded
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (in_rs != '0) rs_val = (wb_act && wb_rd == in_rs) ? wb_data : regs[in_rs];
    if (in_rt != '0) rt_val = (wb_act && wb_rd == in_rt) ? wb_data : regs[in_rt];
  end

  // A register being written back this cycle no longer blocks issue
  always_comb begin
    ebusy = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      ebusy[r] = busy[r] && !(wb_act && wb_rd == AW'(r));
    end
  end

  assign hazard   = ebusy[in_rs] | ebusy[in_rt] | ebusy[in_rd];
  assign space    = !out_valid | out_ready;
  assign in_ready = space & !hazard;
  assign issue    = in_valid & in_ready;

  // Operand output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Fonte1    <= '0;
      Fonte2    <= '0;
      ULAOp     <= 2'b00;
      out_rd    <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      Fonte1    <= rs_val;
      Fonte2    <= rt_val;
      ULAOp     <= in_op;
      out_rd    <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Register bank and scoreboard; a new producer overrides a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      regs[0] <= '0;
      busy[0] <= 1'b0;
      for (int unsigned r = 1; r < NREG; r++) begin
        if (wb_act && wb_rd == AW'(r)) regs[r] <= wb_data;
        if (issue && in_rd == AW'(r))       busy[r] <= 1'b1;
        else if (wb_act && wb_rd == AW'(r)) busy[r] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_estagio_operandos.sv
// Bench for estagio_operandos: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_estagio_operandos;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = '0;
  logic [1:0] in_rd = '0, in_rs = '0, in_rt = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] Fonte1, Fonte2;
  logic [1:0] ULAOp;
  logic [1:0] out_rd;
  logic       wb_en = 1'b0;
  logic [1:0] wb_rd = '0;
  logic [7:0] wb_data = '0;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  estagio_operandos #(.WIDTH(8), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .out_valid(out_valid), .out_ready(out_ready),
    .Fonte1(Fonte1), .Fonte2(Fonte2), .ULAOp(ULAOp), .out_rd(out_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural registers, pending-producer flags, output slot
  logic [7:0] m_reg [4];
  bit         m_busy [4];
  bit         m_ov;
  logic [7:0] m_f1, m_f2;
  logic [1:0] m_op, m_rd;

  function automatic logic [7:0] m_read(input logic [1:0] r);
    if (r == 2'd0) return 8'h00;
    if (wb_en && wb_rd == r) return wb_data;
    return m_reg[r];
  endfunction

  function automatic bit m_blocked(input logic [1:0] r);
    return (r != 2'd0) && m_busy[r] && !(wb_en && wb_rd == r);
  endfunction

  function automatic bit m_accepts();
    return (!m_ov || out_ready) && !m_blocked(in_rs) && !m_blocked(in_rt) && !m_blocked(in_rd);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin m_reg[i] = 8'h00; m_busy[i] = 1'b0; end
      m_ov = 1'b0; m_f1 = 8'h00; m_f2 = 8'h00; m_op = 2'b00; m_rd = 2'b00;
    end else begin
      automatic bit acc = in_valid && m_accepts();
      automatic logic [7:0] a = m_read(in_rs);
      automatic logic [7:0] b = m_read(in_rt);
      if (acc) begin
        m_ov = 1'b1; m_f1 = a; m_f2 = b; m_op = in_op; m_rd = in_rd;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (wb_en && wb_rd != 2'd0) begin
        m_reg[wb_rd] = wb_data;
        m_busy[wb_rd] = 1'b0;
      end
      if (acc && in_rd != 2'd0) m_busy[in_rd] = 1'b1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_in_ready", 32'(in_ready), 32'(m_accepts()));
      check("m_out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        check("m_Fonte1", 32'(Fonte1), 32'(m_f1));
        check("m_Fonte2", 32'(Fonte2), 32'(m_f2));
        check("m_ULAOp", 32'(ULAOp), 32'(m_op));
        check("m_out_rd", 32'(out_rd), 32'(m_rd));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] f1,
                            input logic [7:0] f2, input logic [1:0] op, input logic [1:0] rd);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_f1"}, 32'(Fonte1), 32'(f1));
    check({tag, "_f2"}, 32'(Fonte2), 32'(f2));
    check({tag, "_op"}, 32'(ULAOp), 32'(op));
    check({tag, "_rd"}, 32'(out_rd), 32'(rd));
  endtask

  task automatic set_in(input logic v, input logic [1:0] op, input logic [1:0] rs,
                        input logic [1:0] rt, input logic [1:0] rd);
    in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
  endtask

  task automatic set_wb(input logic en, input logic [1:0] rd, input logic [7:0] d);
    wb_en = en; wb_rd = rd; wb_data = d;
  endtask

  initial begin
    cyc(); cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;
    neg();
    expect_out("reset", 1'b0, 8'h00, 8'h00, 2'b00, 2'b00);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // 1: basic issue
    cyc(); set_wb(1'b1, 2'd1, 8'd2);
    cyc(); set_wb(1'b1, 2'd2, 8'd4);
    cyc(); set_wb(1'b0, 2'd0, 8'd0);
    out_ready = 1'b1;
    set_in(1'b1, 2'b00, 2'd1, 2'd2, 2'd3);
    neg(); check("t1_in_ready", 32'(in_ready), 32'd1);
    cyc();
    // 2: RAW on r3 stalls, then bypass on write-back
    set_in(1'b1, 2'b00, 2'd3, 2'd1, 2'd2);
    neg(); expect_out("t1_out", 1'b1, 8'd2, 8'd4, 2'b00, 2'd3);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) neg();
      check("t2_stall", 32'(in_ready), 32'd0);
      cyc();
    end
    set_wb(1'b1, 2'd3, 8'd6);
    neg(); check("t2_release", 32'(in_ready), 32'd1);
    cyc(); set_wb(1'b0, 2'd0, 8'd0);
    // 3: backpressure holds the slot
    out_ready = 1'b0;
    set_in(1'b1, 2'b10, 2'd1, 2'd3, 2'd1);
    for (int i = 0; i < 4; i++) begin
      neg();
      check("t3_in_ready_low", 32'(in_ready), 32'd0);
      expect_out("t3_hold", 1'b1, 8'd6, 8'd2, 2'b00, 2'd2);
      cyc();
    end
    out_ready = 1'b1;
    neg(); check("t3_in_ready_high", 32'(in_ready), 32'd1);
    cyc(); set_in(1'b0, 2'b00, 2'd0, 2'd0, 2'd0);
    neg(); expect_out("t3_next", 1'b1, 8'd2, 8'd6, 2'b10, 2'd1);
    cyc(); set_wb(1'b1, 2'd1, 8'h11);
    cyc(); set_wb(1'b1, 2'd2, 8'h22);
    cyc(); set_wb(1'b0, 2'd0, 8'd0);
    // 4: r0 ignores writes, reads zero, never becomes busy
    set_wb(1'b1, 2'd0, 8'hFF);
    set_in(1'b1, 2'b01, 2'd0, 2'd0, 2'd0);
    neg(); check("t4_in_ready", 32'(in_ready), 32'd1);
    cyc(); set_wb(1'b0, 2'd0, 8'd0);
    set_in(1'b1, 2'b11, 2'd0, 2'd0, 2'd0);
    neg(); expect_out("t4_out", 1'b1, 8'd0, 8'd0, 2'b01, 2'd0);
    check("t4_no_stall", 32'(in_ready), 32'd1);
    cyc(); set_in(1'b0, 2'b00, 2'd0, 2'd0, 2'd0);
    neg(); expect_out("t4_op11", 1'b1, 8'd0, 8'd0, 2'b11, 2'd0);
    // 5: same-cycle wb and issue to r2 leaves r2 busy
    cyc(); set_wb(1'b1, 2'd2, 8'd9);
    set_in(1'b1, 2'b00, 2'd1, 2'd1, 2'd2);
    neg(); check("t5_in_ready", 32'(in_ready), 32'd1);
    cyc(); set_wb(1'b0, 2'd0, 8'd0);
    set_in(1'b1, 2'b00, 2'd2, 2'd0, 2'd0);
    neg(); expect_out("t5_out", 1'b1, 8'h11, 8'h11, 2'b00, 2'd2);
    check("t5_stall_a", 32'(in_ready), 32'd0);
    cyc();
    neg(); check("t5_stall_b", 32'(in_ready), 32'd0);
    cyc(); set_wb(1'b1, 2'd2, 8'h33);
    neg(); check("t5_release", 32'(in_ready), 32'd1);
    cyc(); set_wb(1'b0, 2'd0, 8'd0); set_in(1'b0, 2'b00, 2'd0, 2'd0, 2'd0);
    neg(); expect_out("t5_bypass", 1'b1, 8'h33, 8'h00, 2'b00, 2'd0);
    // 6: reset with a held slot and r3 busy
    cyc(); set_in(1'b1, 2'b00, 2'd1, 2'd2, 2'd3);
    cyc(); set_in(1'b0, 2'b00, 2'd0, 2'd0, 2'd0); out_ready = 1'b0;
    neg(); check("t6_pre_valid", 32'(out_valid), 32'd1);
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    set_in(1'b1, 2'b10, 2'd1, 2'd3, 2'd3);
    neg(); expect_out("t6_reset", 1'b0, 8'd0, 8'd0, 2'b00, 2'd0);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    cyc(); set_in(1'b0, 2'b00, 2'd0, 2'd0, 2'd0);
    neg(); expect_out("t6_regs_zero", 1'b1, 8'd0, 8'd0, 2'b10, 2'd3);

    // Randomized traffic honouring the hold-while-stalled rule
    for (int n = 0; n < 3000; n++) begin
      automatic bit held;
      neg();
      held = in_valid && !in_ready;
      cyc();
      if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op = 2'($urandom);
        in_rs = 2'($urandom);
        in_rt = 2'($urandom);
        in_rd = 2'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en = ($urandom_range(0, 2) == 0);
      wb_rd = 2'($urandom);
      wb_data = 8'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
    end
    neg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/estagio_operandos.md
Name: estagio_operandos

Overview:
Operand-issue stage directly upstream of the nRISC ALU. It holds the 2^AW x 8-bit register bank, reads two source registers per instruction, and presents Fonte1/Fonte2/ULAOp to the ALU through a one-entry valid/ready output register. A per-register busy scoreboard stalls issue on RAW/WAW hazards until the ALU result is written back. Write-back data is bypassed into the operand read in the same cycle.

Parameters:
WIDTH, 8, data width of registers and operands
AW, 2, register index width; bank has NREG = 2**AW registers, r0 hardwired to zero

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage accepts instruction this cycle
in_op  input  2  ALU operation (00 add, 01 sub, 10 slt)
in_rd  input  AW  destination register index
in_rs  input  AW  source register for Fonte1
in_rt  input  AW  source register for Fonte2
out_valid  output  1  operands valid toward ALU
out_ready  input  1  ALU/downstream consumes operands
Fonte1  output  WIDTH  operand 1
Fonte2  output  WIDTH  operand 2
ULAOp  output  2  operation to ALU
out_rd  output  AW  destination tag travelling with operands
wb_en  input  1  write-back strobe
wb_rd  input  AW  write-back register index
wb_data  input  WIDTH  write-back value (ALU Resultado)

Behaviour:
- Reset (rst_n=0 at rising edge): all registers 0, all busy bits 0, out_valid=0, Fonte1=Fonte2=0, ULAOp=00, out_rd=0. Reset has priority over every other event, including an in-flight handshake or wb.
- Read: rX==0 gives 0. Otherwise, if wb_en && wb_rd==rX && rX!=0, gives wb_data (bypass). Otherwise gives reg[rX].
- Effective busy: ebusy[r] = busy[r] && !(wb_en && wb_rd==r). r0 is never busy.
- hazard = ebusy[in_rs] | ebusy[in_rt] | ebusy[in_rd].
- space = !out_valid | out_ready.
- in_ready = space & !hazard. This is combinational and does not depend on in_valid.
- Issue (in_valid & in_ready):
  - Next edge loads Fonte1/Fonte2 (bypassed reads), ULAOp=in_op, out_rd=in_rd, out_valid=1.
  - If in_rd!=0, sets busy[in_rd].
  - Latency: operands visible 1 cycle after acceptance.
- in_op is passed unchanged, including 11.
- Output handshake: transfer when out_valid & out_ready. With no new issue, out_valid clears next edge. While out_valid & !out_ready, Fonte1/Fonte2/ULAOp/out_rd are held stable.
- Back-to-back: transfer and issue in the same cycle give out_valid=1 continuously, i.e. full throughput of 1 per cycle when there are no hazards.
- Write-back (wb_en & wb_rd!=0): reg[wb_rd] <= wb_data and busy[wb_rd] cleared at the edge. Writes to r0 are ignored.
- Write-back to a non-busy register is legal: data written, busy stays 0.
- Simultaneous wb_rd==in_rd with an issue: data is written and busy ends 1, because the new producer wins.
- Stall: while hazard=1, in_ready=0 and no state changes except write-back. Upstream must hold its fields stable while in_valid=1 and in_ready=0.
- Scoreboard assumes in-order single-outstanding-per-register write-back. A second issue to the same rd is blocked by the WAW check.

Test Plan:
1. Reset, then wb r1=2 and wb r2=4. Issue op=00 rs=1 rt=2 rd=3 -> next cycle out_valid=1, Fonte1=2, Fonte2=4, ULAOp=00, out_rd=3, busy[3]=1.
2. RAW stall and bypass:
   - After test 1 (out_ready=1), present rs=3 rt=1 rd=2 -> in_ready=0 for 3 cycles.
   - Then wb r3=6 in the same cycle -> in_ready=1, accepted, Fonte1=6 (bypass), Fonte2=2, and reg[3]=6 afterwards.
3. Backpressure:
   - out_ready=0 with out_valid=1 -> in_ready=0 and outputs held for 4 cycles.
   - Raise out_ready with a new instruction present -> out_valid stays 1 and new operands appear the next cycle.
4. r0 handling:
   - wb r0=0xFF -> reg unchanged.
   - Issue rs=0 rt=0 rd=0 op=01 -> Fonte1=Fonte2=0, no busy set.
   - Immediately issue rd=0 again -> no stall.
5. Same-cycle wb and issue to the same rd:
   - wb r2=9 while issuing rd=2 (r2 not busy) -> reg[2]=9, busy[2]=1.
   - A following read of r2 stalls until the next wb r2.
6. Reset mid-operation: rst_n=0 for 1 cycle while out_valid=1, out_ready=0 and busy[3]=1 -> next cycle out_valid=0, all busy=0, all regs=0, outputs=0, in_ready=1.
